// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage; owns the PC and the IF/ID register.
// Optional fetch-address (AdEL) check is compiled in with `define IF_ADEL_CHECK_EN.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   Stall                hazard stall: PC and IF/ID hold
//   ErrSignal            exception taken: redirect to EXC_VECTOR and flush
//   eretEn, EPCData      eret taken: redirect to EPCData and flush
//   branch, branch_addr32  taken branch and its target, resolved in ID
//   jump, jump_addr32    taken jump and its target, resolved in ID
//   CtrlTypeInstr_ID     ID holds a branch/jump, so this fetch is a delay slot
//   IMAddr / IMData      combinational instruction-memory port
//   *_IF_to_ID           registered IF/ID bundle toward decode
module if_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        ErrSignal,
    input  logic        eretEn,
    input  logic [31:0] EPCData,
    input  logic        branch,
    input  logic        jump,
    input  logic [31:0] branch_addr32,
    input  logic [31:0] jump_addr32,
    input  logic        CtrlTypeInstr_ID,
    output logic [31:0] IMAddr,
    input  logic [31:0] IMData,
    output logic [31:0] Instr_IF_to_ID,
    output logic [31:0] PC_IF_to_ID,
    output logic [31:0] PC_4_IF_to_ID,
    output logic [4:0]  ErrStat_IF_to_ID,
    output logic        Err_IF_to_ID,
    output logic        BD_IF_to_ID
);

    localparam logic [4:0] EXC_NONE = 5'd31;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // A misaligned or inverted legal window is a configuration mistake.
    if (IM_LO[1:0] != 2'b00 || IM_HI[1:0] != 2'b00 || IM_HI < IM_LO) begin : g_bad_range
        $error("if_stage: illegal instruction-memory window");
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  errstat;
        logic        err;
        logic        bd;
    } if_id_t;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] redirect;
    logic        flush;
    logic        fetch_err;
    if_id_t      if_id;
    if_id_t      if_id_next;

    assign IMAddr   = pc;
    assign pc_plus4 = pc + 32'd4;

`ifdef IF_ADEL_CHECK_EN
    assign fetch_err = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
`else
    assign fetch_err = 1'b0;
`endif

    // Exception beats eret when both arrive together.
    assign flush    = ErrSignal | eretEn;
    assign redirect = ErrSignal ? EXC_VECTOR : EPCData;

    always_comb begin
        pc_next = pc_plus4;
        if (flush)
            pc_next = redirect;
        else if (Stall)
            pc_next = pc;
        else if (jump)
            pc_next = jump_addr32;
        else if (branch)
            pc_next = branch_addr32;
    end

    // The delay-slot fetch is always latched; only a flush discards it.
    always_comb begin
        if_id_next = if_id;
        if (flush) begin
            if_id_next.instr   = 32'd0;
            if_id_next.pc      = redirect;
            if_id_next.pc4     = redirect + 32'd4;
            if_id_next.errstat = EXC_NONE;
            if_id_next.err     = 1'b0;
            if_id_next.bd      = 1'b0;
        end else if (!Stall) begin
            if_id_next.instr   = fetch_err ? 32'd0 : IMData;
            if_id_next.pc      = pc;
            if_id_next.pc4     = pc_plus4;
            if_id_next.errstat = fetch_err ? EXC_ADEL : EXC_NONE;
            if_id_next.err     = fetch_err;
            if_id_next.bd      = CtrlTypeInstr_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= PC_RESET;
            if_id.instr   <= 32'd0;
            if_id.pc      <= PC_RESET;
            if_id.pc4     <= PC_RESET + 32'd4;
            if_id.errstat <= EXC_NONE;
            if_id.err     <= 1'b0;
            if_id.bd      <= 1'b0;
        end else begin
            pc    <= pc_next;
            if_id <= if_id_next;
        end
    end

    assign Instr_IF_to_ID   = if_id.instr;
    assign PC_IF_to_ID      = if_id.pc;
    assign PC_4_IF_to_ID    = if_id.pc4;
    assign ErrStat_IF_to_ID = if_id.errstat;
    assign Err_IF_to_ID     = if_id.err;
    assign BD_IF_to_ID      = if_id.bd;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
// Instruction memory is modelled as IMData = ~IMAddr.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic        ErrSignal = 1'b0;
    logic        eretEn = 1'b0;
    logic [31:0] EPCData = 32'd0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] branch_addr32 = 32'd0;
    logic [31:0] jump_addr32 = 32'd0;
    logic        CtrlTypeInstr_ID = 1'b0;
    logic [31:0] IMAddr;
    logic [31:0] IMData;
    logic [31:0] Instr_IF_to_ID;
    logic [31:0] PC_IF_to_ID;
    logic [31:0] PC_4_IF_to_ID;
    logic [4:0]  ErrStat_IF_to_ID;
    logic        Err_IF_to_ID;
    logic        BD_IF_to_ID;

    int total = 0;
    int bad = 0;

    if_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .ErrSignal(ErrSignal),
        .eretEn(eretEn), .EPCData(EPCData), .branch(branch), .jump(jump),
        .branch_addr32(branch_addr32), .jump_addr32(jump_addr32),
        .CtrlTypeInstr_ID(CtrlTypeInstr_ID), .IMAddr(IMAddr), .IMData(IMData),
        .Instr_IF_to_ID(Instr_IF_to_ID), .PC_IF_to_ID(PC_IF_to_ID),
        .PC_4_IF_to_ID(PC_4_IF_to_ID), .ErrStat_IF_to_ID(ErrStat_IF_to_ID),
        .Err_IF_to_ID(Err_IF_to_ID), .BD_IF_to_ID(BD_IF_to_ID)
    );

    always #5 clk = ~clk;
    assign IMData = ~IMAddr;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        Stall = 0; ErrSignal = 0; eretEn = 0; branch = 0; jump = 0;
        CtrlTypeInstr_ID = 0;
    endtask

    // Jump to a target with the jump in ID; leaves PC = target.
    task automatic go_to(input logic [31:0] a);
        jump = 1; jump_addr32 = a; CtrlTypeInstr_ID = 1;
        step();
        clear_ctrl();
    endtask

    task automatic test_reset();
        reset = 1;
        step(); step();
        reset = 0;
        total++; if (IMAddr !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h exp=3000", IMAddr); end
        total++; if (Instr_IF_to_ID !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", Instr_IF_to_ID); end
        total++; if (PC_IF_to_ID !== 32'h3000) begin bad++; $display("FAIL reset_ifpc got=%h exp=3000", PC_IF_to_ID); end
        total++; if (PC_4_IF_to_ID !== 32'h3004) begin bad++; $display("FAIL reset_pc4 got=%h exp=3004", PC_4_IF_to_ID); end
        total++; if (ErrStat_IF_to_ID !== 5'd31) begin bad++; $display("FAIL reset_errstat got=%0d exp=31", ErrStat_IF_to_ID); end
        total++; if (Err_IF_to_ID !== 1'b0 || BD_IF_to_ID !== 1'b0) begin bad++; $display("FAIL reset_err_bd got=%b%b exp=00", Err_IF_to_ID, BD_IF_to_ID); end
    endtask

    task automatic test_free_run();
        step();
        total++; if (IMAddr !== 32'h3004) begin bad++; $display("FAIL run1_pc got=%h exp=3004", IMAddr); end
        total++; if (PC_IF_to_ID !== 32'h3000 || Instr_IF_to_ID !== ~32'h3000) begin bad++; $display("FAIL run1_ifid got=%h/%h exp=3000/%h", PC_IF_to_ID, Instr_IF_to_ID, ~32'h3000); end
        step();
        total++; if (IMAddr !== 32'h3008) begin bad++; $display("FAIL run2_pc got=%h exp=3008", IMAddr); end
        total++; if (PC_IF_to_ID !== 32'h3004 || PC_4_IF_to_ID !== 32'h3008 || BD_IF_to_ID !== 1'b0) begin bad++; $display("FAIL run2_ifid got=%h/%h/%b exp=3004/3008/0", PC_IF_to_ID, PC_4_IF_to_ID, BD_IF_to_ID); end
    endtask

    task automatic test_branch();
        branch = 1; branch_addr32 = 32'h3100; CtrlTypeInstr_ID = 1;
        step();
        clear_ctrl();
        total++; if (IMAddr !== 32'h3100) begin bad++; $display("FAIL br_target got=%h exp=3100", IMAddr); end
        total++; if (PC_IF_to_ID !== 32'h3008 || BD_IF_to_ID !== 1'b1) begin bad++; $display("FAIL br_slot got=%h/%b exp=3008/1", PC_IF_to_ID, BD_IF_to_ID); end
        step();
        total++; if (PC_IF_to_ID !== 32'h3100 || BD_IF_to_ID !== 1'b0 || IMAddr !== 32'h3104) begin bad++; $display("FAIL br_after got=%h/%b/%h exp=3100/0/3104", PC_IF_to_ID, BD_IF_to_ID, IMAddr); end
    endtask

    task automatic test_stall();
        go_to(32'h3010);
        Stall = 1; branch = 1; branch_addr32 = 32'h3200;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (IMAddr !== 32'h3010) begin bad++; $display("FAIL stall_pc%0d got=%h exp=3010", i, IMAddr); end
            total++; if (PC_IF_to_ID !== 32'h3104 || BD_IF_to_ID !== 1'b1 || Instr_IF_to_ID !== ~32'h3104) begin bad++; $display("FAIL stall_ifid%0d got=%h/%b/%h exp=3104/1/%h", i, PC_IF_to_ID, BD_IF_to_ID, Instr_IF_to_ID, ~32'h3104); end
        end
        clear_ctrl();
        step();
        total++; if (IMAddr !== 32'h3014 || PC_IF_to_ID !== 32'h3010) begin bad++; $display("FAIL stall_release got=%h/%h exp=3014/3010", IMAddr, PC_IF_to_ID); end
    endtask

    task automatic test_flush();
        go_to(32'h3020);
        ErrSignal = 1; Stall = 1;
        step();
        clear_ctrl();
        total++; if (IMAddr !== 32'h4180) begin bad++; $display("FAIL exc_pc got=%h exp=4180", IMAddr); end
        total++; if (Instr_IF_to_ID !== 32'h0 || PC_IF_to_ID !== 32'h4180 || PC_4_IF_to_ID !== 32'h4184) begin bad++; $display("FAIL exc_ifid got=%h/%h/%h exp=0/4180/4184", Instr_IF_to_ID, PC_IF_to_ID, PC_4_IF_to_ID); end
        total++; if (Err_IF_to_ID !== 1'b0 || ErrStat_IF_to_ID !== 5'd31 || BD_IF_to_ID !== 1'b0) begin bad++; $display("FAIL exc_status got=%b/%0d/%b exp=0/31/0", Err_IF_to_ID, ErrStat_IF_to_ID, BD_IF_to_ID); end
        eretEn = 1; EPCData = 32'h3044; CtrlTypeInstr_ID = 1;
        step();
        clear_ctrl();
        total++; if (IMAddr !== 32'h3044) begin bad++; $display("FAIL eret_pc got=%h exp=3044", IMAddr); end
        total++; if (Instr_IF_to_ID !== 32'h0 || PC_IF_to_ID !== 32'h3044 || PC_4_IF_to_ID !== 32'h3048 || BD_IF_to_ID !== 1'b0) begin bad++; $display("FAIL eret_ifid got=%h/%h/%h/%b exp=0/3044/3048/0", Instr_IF_to_ID, PC_IF_to_ID, PC_4_IF_to_ID, BD_IF_to_ID); end
        eretEn = 1; ErrSignal = 1; EPCData = 32'h3500;
        step();
        clear_ctrl();
        total++; if (IMAddr !== 32'h4180 || PC_IF_to_ID !== 32'h4180) begin bad++; $display("FAIL both_pc got=%h/%h exp=4180/4180", IMAddr, PC_IF_to_ID); end
    endtask

    task automatic test_adel();
        go_to(32'h3002);
        total++; if (IMAddr !== 32'h3002 || BD_IF_to_ID !== 1'b1 || PC_IF_to_ID !== 32'h4180) begin bad++; $display("FAIL adel_jump got=%h/%b/%h exp=3002/1/4180", IMAddr, BD_IF_to_ID, PC_IF_to_ID); end
        step();
        total++; if (IMAddr !== 32'h3006 || PC_IF_to_ID !== 32'h3002) begin bad++; $display("FAIL adel_adv got=%h/%h exp=3006/3002", IMAddr, PC_IF_to_ID); end
`ifdef IF_ADEL_CHECK_EN
        total++; if (Err_IF_to_ID !== 1'b1 || ErrStat_IF_to_ID !== 5'd4 || Instr_IF_to_ID !== 32'h0) begin bad++; $display("FAIL adel_flag got=%b/%0d/%h exp=1/4/0", Err_IF_to_ID, ErrStat_IF_to_ID, Instr_IF_to_ID); end
`else
        total++; if (Err_IF_to_ID !== 1'b0 || ErrStat_IF_to_ID !== 5'd31 || Instr_IF_to_ID !== ~32'h3002) begin bad++; $display("FAIL adel_off got=%b/%0d/%h exp=0/31/%h", Err_IF_to_ID, ErrStat_IF_to_ID, Instr_IF_to_ID, ~32'h3002); end
`endif
        go_to(32'h6FFC);
        step();
        total++; if (PC_IF_to_ID !== 32'h6FFC || Err_IF_to_ID !== 1'b0 || Instr_IF_to_ID !== ~32'h6FFC) begin bad++; $display("FAIL hi_edge got=%h/%b/%h exp=6ffc/0/%h", PC_IF_to_ID, Err_IF_to_ID, Instr_IF_to_ID, ~32'h6FFC); end
        step();
        total++; if (PC_IF_to_ID !== 32'h7000) begin bad++; $display("FAIL hi_over_pc got=%h exp=7000", PC_IF_to_ID); end
`ifdef IF_ADEL_CHECK_EN
        total++; if (Err_IF_to_ID !== 1'b1 || ErrStat_IF_to_ID !== 5'd4) begin bad++; $display("FAIL hi_over got=%b/%0d exp=1/4", Err_IF_to_ID, ErrStat_IF_to_ID); end
`else
        total++; if (Err_IF_to_ID !== 1'b0 || Instr_IF_to_ID !== ~32'h7000) begin bad++; $display("FAIL hi_over_off got=%b/%h exp=0/%h", Err_IF_to_ID, Instr_IF_to_ID, ~32'h7000); end
`endif
        go_to(32'h2FFC);
        step();
`ifdef IF_ADEL_CHECK_EN
        total++; if (Err_IF_to_ID !== 1'b1 || PC_IF_to_ID !== 32'h2FFC) begin bad++; $display("FAIL lo_under got=%b/%h exp=1/2ffc", Err_IF_to_ID, PC_IF_to_ID); end
`else
        total++; if (Err_IF_to_ID !== 1'b0 || PC_IF_to_ID !== 32'h2FFC) begin bad++; $display("FAIL lo_under_off got=%b/%h exp=0/2ffc", Err_IF_to_ID, PC_IF_to_ID); end
`endif
        total++; if (IMAddr !== 32'h3000) begin bad++; $display("FAIL lo_adv got=%h exp=3000", IMAddr); end
        step();
        total++; if (Err_IF_to_ID !== 1'b0 || ErrStat_IF_to_ID !== 5'd31 || Instr_IF_to_ID !== ~32'h3000) begin bad++; $display("FAIL lo_edge got=%b/%0d/%h exp=0/31/%h", Err_IF_to_ID, ErrStat_IF_to_ID, Instr_IF_to_ID, ~32'h3000); end
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        step();
        total++; if (IMAddr !== 32'h0 || PC_4_IF_to_ID !== 32'h0) begin bad++; $display("FAIL wrap got=%h/%h exp=0/0", IMAddr, PC_4_IF_to_ID); end
    endtask

    task automatic test_reset_priority();
        go_to(32'h3300);
        Stall = 1; ErrSignal = 1; reset = 1;
        step();
        clear_ctrl();
        reset = 0;
        total++; if (IMAddr !== 32'h3000 || PC_IF_to_ID !== 32'h3000 || BD_IF_to_ID !== 1'b0) begin bad++; $display("FAIL rst_prio got=%h/%h/%b exp=3000/3000/0", IMAddr, PC_IF_to_ID, BD_IF_to_ID); end
        step();
        total++; if (IMAddr !== 32'h3004) begin bad++; $display("FAIL rst_resume got=%h exp=3004", IMAddr); end
    endtask

    initial begin
        #2;
        test_reset();
        test_free_run();
        test_branch();
        test_stall();
        test_flush();
        test_adel();
        test_wrap();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
